vegeta_sparse_mac_pe: RTL and testbench

- Next-generation systolic processing element for the VEGETA sparse GEMM array.
- Holds NBUF banks of compressed weights. Each bank stores N_MAX nonzero weights plus per-weight metadata indices.
- Selects matching activations from an M-wide activation block and multiplies them in N_MAX parallel lanes.
- Reduces the lane products with the incoming partial sum through a 2-stage pipeline. Weights, activations and partial sums are forwarded to neighbour PEs.

---
 rtl/vTPU_pkg.sv | 17 +
 rtl/vegeta_lane_select_mul.sv | 52 +++++
 rtl/vegeta_sparse_mac_pe.sv | 186 ++++++++++++++++++
 tb/tb_vegeta_sparse_mac_pe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vTPU_pkg.sv
// rtl/vTPU_pkg.sv - shared types and helpers for the VEGETA sparse PE
package vTPU_pkg;

  // Sparsity mode as sampled with each activation block; 11 is reserved and treated as dense
  typedef enum logic [1:0] {
    SP_DENSE = 2'b00,
    SP_NM    = 2'b01,
    SP_1M    = 2'b10,
    SP_RSVD  = 2'b11
  } sp_mode_e;

  // Width of one compressed-weight lane slice: weight value plus its metadata index
  function automatic int lane_slice_w(input int mul_w, input int meta_w);
    return mul_w + meta_w;
  endfunction

endpackage

// File: rtl/vegeta_lane_select_mul.sv
// rtl/vegeta_lane_select_mul.sv - per-lane activation select and signed multiply
module vegeta_lane_select_mul
  import vTPU_pkg::*;
#(
  parameter int MUL_W = 8,
  parameter int M     = 4,
  parameter int LANE  = 0,
  localparam int META_W = $clog2(M)
) (
  input  sp_mode_e                  mode,
  input  logic [M*MUL_W-1:0]        act_in,
  input  logic signed [MUL_W-1:0]   weight,
  input  logic [META_W-1:0]         meta,
  output logic signed [2*MUL_W-1:0] product
);

  logic [META_W-1:0]         sel_idx;
  logic                      lane_en;
  logic signed [MUL_W-1:0]   act_sel;
  logic signed [2*MUL_W-1:0] act_ext;
  logic signed [2*MUL_W-1:0] w_ext;

  // Pick the activation index for this lane; only lane 0 survives in 1:M mode
  always_comb begin
    sel_idx = META_W'(LANE);
    lane_en = 1'b1;
    case (mode)
      SP_NM:   sel_idx = meta;
      SP_1M: begin
        sel_idx = meta;
        lane_en = (LANE == 0);
      end
      default: sel_idx = META_W'(LANE);
    endcase
  end

  // Activation mux written as a compare loop so the index never needs a width-changing multiply
  always_comb begin
    act_sel = '0;
    for (int j = 0; j < M; j++) begin
      if (sel_idx == META_W'(j)) act_sel = act_in[j*MUL_W +: MUL_W];
    end
  end

  // Both operands sign-extended to full product width so the multiply is exact
  always_comb begin
    act_ext = {{MUL_W{act_sel[MUL_W-1]}}, act_sel};
    w_ext   = {{MUL_W{weight[MUL_W-1]}}, weight};
    product = lane_en ? act_ext * w_ext : '0;
  end

endmodule

// File: rtl/vegeta_sparse_mac_pe.sv
// rtl/vegeta_sparse_mac_pe.sv - sparse systolic MAC PE; VEGETA_MAC_SAT_EN enables saturating accumulate and acc_sat
module vegeta_sparse_mac_pe
  import vTPU_pkg::*;
#(
  parameter int MUL_W = 8,
  parameter int ACC_W = 32,
  parameter int M     = 4,
  parameter int N_MAX = 2,
  parameter int NBUF  = 2,
  localparam int META_W = $clog2(M),
  localparam int LANE_W = MUL_W + META_W,
  localparam int WORD_W = N_MAX * LANE_W,
  localparam int BANK_W = $clog2(NBUF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         sp_mode,
  input  logic               w_valid_in,
  input  logic [WORD_W-1:0]  w_in,
  input  logic [BANK_W-1:0]  w_bank_wr,
  output logic               w_valid_out,
  output logic [WORD_W-1:0]  w_out,
  output logic [BANK_W-1:0]  w_bank_wr_out,
  input  logic               in_valid,
  input  logic [M*MUL_W-1:0] act_in,
  input  logic [ACC_W-1:0]   acc_in,
  input  logic [BANK_W-1:0]  w_bank_rd,
  output logic               act_valid_out,
  output logic [M*MUL_W-1:0] act_out,
  output logic               acc_valid,
  output logic [ACC_W-1:0]   acc_out,
  output logic               bank_conflict
`ifdef VEGETA_MAC_SAT_EN
  ,
  output logic               acc_sat
`endif
);

`ifdef VEGETA_MAC_SAT_EN
  localparam int SUM_W = ACC_W + 1;
`else
  localparam int SUM_W = ACC_W;
`endif

  logic [WORD_W-1:0]         bank_q [NBUF];
  logic [WORD_W-1:0]         rd_word;
  sp_mode_e                  mode_e;
  logic signed [2*MUL_W-1:0] prod_d [N_MAX];
  logic signed [2*MUL_W-1:0] prod_q [N_MAX];
  logic [ACC_W-1:0]          acc_q;
  logic                      s1_valid;
  logic signed [SUM_W-1:0]   sum_ext;
  logic [ACC_W-1:0]          acc_next;
  logic                      sat_next;

  assign mode_e  = sp_mode_e'(sp_mode);
  // Combinational read sees the pre-edge contents, so a same-cycle write never leaks into compute
  assign rd_word = bank_q[w_bank_rd];

  // Weight banks: written on w_valid_in, cleared on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NBUF; i++) bank_q[i] <= '0;
    end else if (w_valid_in && (int'(w_bank_wr) < NBUF)) begin
      bank_q[w_bank_wr] <= w_in;
    end
  end

  // Weight forwarding to the neighbour PE; data holds while no new word arrives
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_valid_out   <= 1'b0;
      w_out         <= '0;
      w_bank_wr_out <= '0;
    end else begin
      w_valid_out <= w_valid_in;
      if (w_valid_in) begin
        w_out         <= w_in;
        w_bank_wr_out <= w_bank_wr;
      end
    end
  end

  // Activation forwarding, independent of sparsity mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_valid_out <= 1'b0;
      act_out       <= '0;
    end else begin
      act_valid_out <= in_valid;
      act_out       <= act_in;
    end
  end

  // Sticky flag for a write and a compute read hitting the same bank in one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_conflict <= 1'b0;
    end else if (w_valid_in && in_valid && (w_bank_wr == w_bank_rd)) begin
      bank_conflict <= 1'b1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_MAX; k++) begin : g_lane
      vegeta_lane_select_mul #(
        .MUL_W (MUL_W),
        .M     (M),
        .LANE  (k)
      ) u_lane (
        .mode    (mode_e),
        .act_in  (act_in),
        .weight  (rd_word[k*LANE_W +: MUL_W]),
        .meta    (rd_word[k*LANE_W+MUL_W +: META_W]),
        .product (prod_d[k])
      );
    end
  endgenerate

  // Stage 1: register lane products with the incoming partial sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      acc_q    <= '0;
      for (int i = 0; i < N_MAX; i++) prod_q[i] <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        acc_q <= acc_in;
        for (int i = 0; i < N_MAX; i++) prod_q[i] <= prod_d[i];
      end
    end
  end

  // Stage 2 adder: partial sum plus sign-extended lane products, then wrap or clamp
  always_comb begin
`ifdef VEGETA_MAC_SAT_EN
    sum_ext = {acc_q[ACC_W-1], acc_q};
`else
    sum_ext = acc_q;
`endif
    for (int i = 0; i < N_MAX; i++) begin
      sum_ext = sum_ext + {{(SUM_W-2*MUL_W){prod_q[i][2*MUL_W-1]}}, prod_q[i]};
    end
`ifdef VEGETA_MAC_SAT_EN
    sat_next = (sum_ext[ACC_W] != sum_ext[ACC_W-1]);
    if (!sat_next) begin
      acc_next = sum_ext[ACC_W-1:0];
    end else if (sum_ext[ACC_W]) begin
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
    end else begin
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    sat_next = 1'b0;
    acc_next = sum_ext;
`endif
  end

  // Stage 2 register: result holds while no block completes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_valid <= 1'b0;
      acc_out   <= '0;
    end else begin
      acc_valid <= s1_valid;
      if (s1_valid) acc_out <= acc_next;
    end
  end

`ifdef VEGETA_MAC_SAT_EN
  // Clamp indicator travels with acc_out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_sat <= 1'b0;
    end else if (s1_valid) begin
      acc_sat <= sat_next;
    end
  end
`else
  logic unused_sat;
  assign unused_sat = sat_next;
`endif

endmodule

// File: tb/tb_vegeta_sparse_mac_pe.sv
// tb/tb_vegeta_sparse_mac_pe.sv - scoreboard bench for vegeta_sparse_mac_pe; honours VEGETA_MAC_SAT_EN
module tb_vegeta_sparse_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sp_mode;
  logic        w_valid_in;
  logic [19:0] w_in;
  logic [0:0]  w_bank_wr;
  logic        w_valid_out;
  logic [19:0] w_out;
  logic [0:0]  w_bank_wr_out;
  logic        in_valid;
  logic [31:0] act_in;
  logic [31:0] acc_in;
  logic [0:0]  w_bank_rd;
  logic        act_valid_out;
  logic [31:0] act_out;
  logic        acc_valid;
  logic [31:0] acc_out;
  logic        bank_conflict;
`ifdef VEGETA_MAC_SAT_EN
  logic        acc_sat;
`endif

  typedef struct {
    logic [31:0] acc;
    logic        sat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  vegeta_sparse_mac_pe dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sp_mode       (sp_mode),
    .w_valid_in    (w_valid_in),
    .w_in          (w_in),
    .w_bank_wr     (w_bank_wr),
    .w_valid_out   (w_valid_out),
    .w_out         (w_out),
    .w_bank_wr_out (w_bank_wr_out),
    .in_valid      (in_valid),
    .act_in        (act_in),
    .acc_in        (acc_in),
    .w_bank_rd     (w_bank_rd),
    .act_valid_out (act_valid_out),
    .act_out       (act_out),
    .acc_valid     (acc_valid),
    .acc_out       (acc_out),
    .bank_conflict (bank_conflict)
`ifdef VEGETA_MAC_SAT_EN
    ,
    .acc_sat       (acc_sat)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [19:0] pack_w(input int w0, input int m0, input int w1, input int m1);
    return {m1[1:0], w1[7:0], m0[1:0], w0[7:0]};
  endfunction

  function automatic logic [31:0] pack_a(input int a0, input int a1, input int a2, input int a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  task automatic step(input logic wv, input int wbank, input logic [19:0] wword,
                      input logic iv, input logic [1:0] mode, input int rd,
                      input logic [31:0] act, input logic [31:0] acc,
                      input logic [31:0] exp_acc, input logic exp_sat);
    exp_t e;
    w_valid_in = wv;
    w_bank_wr  = wbank[0:0];
    w_in       = wword;
    in_valid   = iv;
    sp_mode    = mode;
    w_bank_rd  = rd[0:0];
    act_in     = act;
    acc_in     = acc;
    if (iv) begin
      e.acc = exp_acc;
      e.sat = exp_sat;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    w_valid_in = 1'b0;
    in_valid   = 1'b0;
  endtask

  task automatic wr(input int bank, input logic [19:0] word);
    step(1'b1, bank, word, 1'b0, 2'b00, 0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic go(input logic [1:0] mode, input int rd, input logic [31:0] act,
                    input logic [31:0] acc, input logic [31:0] exp_acc, input logic exp_sat);
    step(1'b0, 0, 20'h0, 1'b1, mode, rd, act, acc, exp_acc, exp_sat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
  endtask

  // Monitor: every acc_valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && acc_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_acc_valid: got acc_out 0x%08h with no block outstanding", acc_out);
      end else begin
        e = sb_q.pop_front();
        check("acc_out", acc_out, e.acc);
`ifdef VEGETA_MAC_SAT_EN
        check("acc_sat", 32'(acc_sat), 32'(e.sat));
`endif
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    sp_mode    = 2'b00;
    w_valid_in = 1'b0;
    w_in       = '0;
    w_bank_wr  = '0;
    in_valid   = 1'b0;
    act_in     = '0;
    acc_in     = '0;
    w_bank_rd  = '0;
    idle(3);
    check("rst_acc_valid", 32'(acc_valid), 32'd0);
    check("rst_acc_out", acc_out, 32'd0);
    check("rst_w_valid_out", 32'(w_valid_out), 32'd0);
    check("rst_act_valid_out", 32'(act_valid_out), 32'd0);
    check("rst_bank_conflict", 32'(bank_conflict), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Empty banks after reset: result is the incoming partial sum
    go(2'b00, 0, pack_a(1, 2, 7, 4), 32'd5, 32'd5, 1'b0);

    // Weight path forwarding and hold
    wr(0, pack_w(3, 0, 5, 0));
    check("w_valid_out", 32'(w_valid_out), 32'd1);
    check("w_out", 32'(w_out), 32'(pack_w(3, 0, 5, 0)));
    check("w_bank_wr_out", 32'(w_bank_wr_out), 32'd0);
    idle(1);
    check("w_valid_out_drop", 32'(w_valid_out), 32'd0);
    check("w_out_hold", 32'(w_out), 32'(pack_w(3, 0, 5, 0)));

    // Dense: 10 + 3*1 + 5*2, with exact 2-cycle latency
    go(2'b00, 0, pack_a(1, 2, 7, 4), 32'd10, 32'd23, 1'b0);
    check("latency_t1_valid", 32'(acc_valid), 32'd0);
    check("act_valid_out", 32'(act_valid_out), 32'd1);
    check("act_out", act_out, pack_a(1, 2, 7, 4));
    idle(1);
    check("latency_t2_valid", 32'(acc_valid), 32'd1);
    check("latency_t2_acc", acc_out, 32'd23);

    // Compute bank0 while writing bank1: 2*3 + 3*5 - 1
    step(1'b1, 1, pack_w(-2, 3, 6, 0), 1'b1, 2'b00, 0, pack_a(2, 3, 0, 0), -32'sd1, 32'd20, 1'b0);
    check("no_conflict", 32'(bank_conflict), 32'd0);

    // 2:4 on bank1: -2*(-4) + 6*9
    go(2'b01, 1, pack_a(9, 0, 0, -4), 32'd0, 32'd62, 1'b0);

    // 1:4 on bank0: 7*(-3), lane1 ignored
    wr(0, pack_w(7, 2, 100, 1));
    go(2'b10, 0, pack_a(0, 50, -3, 0), 32'd0, -32'sd21, 1'b0);

    // Back-to-back with per-block mode changes, including the reserved code
    go(2'b00, 0, pack_a(0, 50, -3, 0), 32'd1, 32'd5001, 1'b0);
    go(2'b01, 0, pack_a(0, 50, -3, 0), 32'd1, 32'd4980, 1'b0);
    go(2'b10, 0, pack_a(0, 50, -3, 0), 32'd1, -32'sd20, 1'b0);
    go(2'b11, 0, pack_a(0, 50, -3, 0), 32'd1, 32'd5001, 1'b0);

    // Same-bank write and read: old weights 7*1 + 100*2, flag latches
    step(1'b1, 0, pack_w(1, 0, 1, 0), 1'b1, 2'b00, 0, pack_a(1, 2, 0, 0), 32'd0, 32'd207, 1'b0);
    check("conflict_set", 32'(bank_conflict), 32'd1);
    go(2'b00, 0, pack_a(1, 2, 0, 0), 32'd0, 32'd3, 1'b0);
    idle(1);
    check("conflict_sticky", 32'(bank_conflict), 32'd1);

    // Duplicate metadata: both lanes read element 3
    wr(1, pack_w(2, 3, 3, 3));
    go(2'b01, 1, pack_a(0, 0, 0, 5), 32'd0, 32'd25, 1'b0);

    // Positive and negative overflow
    wr(1, pack_w(127, 0, 0, 0));
`ifdef VEGETA_MAC_SAT_EN
    go(2'b00, 1, pack_a(127, 0, 0, 0), 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
`else
    go(2'b00, 1, pack_a(127, 0, 0, 0), 32'h7FFFFFFF, 32'h80003F00, 1'b0);
`endif
    wr(1, pack_w(-128, 0, 0, 0));
`ifdef VEGETA_MAC_SAT_EN
    go(2'b00, 1, pack_a(127, 0, 0, 0), 32'h80000000, 32'h80000000, 1'b1);
`else
    go(2'b00, 1, pack_a(127, 0, 0, 0), 32'h80000000, 32'h7FFFC080, 1'b0);
`endif
    drain();

    // Reset mid-stream: first block completes, second is discarded
    go(2'b00, 0, pack_a(4, 5, 0, 0), 32'd0, 32'd9, 1'b0);
    go(2'b00, 0, pack_a(1, 1, 0, 0), 32'd0, 32'd2, 1'b0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_acc_valid", 32'(acc_valid), 32'd0);
    check("midrst_acc_out", acc_out, 32'd0);
    check("midrst_act_valid_out", 32'(act_valid_out), 32'd0);
    check("midrst_w_out", 32'(w_out), 32'd0);
    check("midrst_bank_conflict", 32'(bank_conflict), 32'd0);
    sb_q.delete();
    rst_n = 1'b1;
    idle(1);
    check("post_rst_acc_valid", 32'(acc_valid), 32'd0);

    // Banks were cleared by reset
    go(2'b00, 0, pack_a(1, 1, 0, 0), 32'd7, 32'd7, 1'b0);
    drain();
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
